// File: rtl/gpu_result_collector.sv
// Deserializes the core array's serial result stream into words and
// buffers them in a small FIFO drained through a valid/ready handshake.
//
// Ports:
//   clk, rst         GPU clock; synchronous active-high reset
//   valid_bit        qualifies output_bit this cycle
//   output_bit       serial result bit, MSB of each word first
//   flush            drops the partial word and empties the FIFO
//   clear_overflow   clears the sticky overflow flag
//   word_data        head-of-FIFO word (combinational from the head entry)
//   word_valid       FIFO non-empty
//   word_ready       consumer takes the head word when word_valid is high
//   level            number of buffered words, 0..DEPTH
//   overflow         sticky; a completed word was dropped
module gpu_result_collector #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_bit,
    input  logic                     output_bit,
    input  logic                     flush,
    input  logic                     clear_overflow,
    output logic [BIT_WIDTH-1:0]     word_data,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [BIT_WIDTH-1:0] sr;
    logic [BIT_WIDTH-1:0] word_next;
    logic [CW-1:0]        bcnt;
    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;

    logic bit_ok;
    logic word_done;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign word_next  = {sr[BIT_WIDTH-2:0], output_bit};
    assign word_valid = (level != '0);
    assign word_data  = mem[rptr];
    assign full       = (level == LW'(DEPTH));

    // Flush masks both the incoming bit and the consumer's pop.
    assign bit_ok    = valid_bit && !flush;
    assign word_done = bit_ok && (bcnt == CW'(BIT_WIDTH - 1));
    assign pop       = word_valid && word_ready && !flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = word_done && (!full || pop);
    assign drop      = word_done && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            bcnt     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Set wins over clear; flush leaves the flag alone.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end

            if (flush) begin
                sr    <= '0;
                bcnt  <= '0;
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (bit_ok) begin
                    sr   <= word_next;
                    bcnt <= word_done ? '0 : bcnt + CW'(1);
                end
                if (push) begin
                    mem[wptr] <= word_next;
                    wptr      <= wptr + PW'(1);
                end
                if (pop) begin
                    rptr <= rptr + PW'(1);
                end
                if (push && !pop) begin
                    level <= level + LW'(1);
                end else if (pop && !push) begin
                    level <= level - LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_result_collector.sv
// Randomized and directed stimulus for gpu_result_collector, checked
// against a queue-based reference model by an independent monitor.
module tb_gpu_result_collector;

    localparam int BW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_bit;
    logic          output_bit;
    logic          flush;
    logic          clear_overflow;
    logic [BW-1:0] word_data;
    logic          word_valid;
    logic          word_ready;
    logic [2:0]    level;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    gpu_result_collector #(.BIT_WIDTH(BW), .DEPTH(DP)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_bit      (valid_bit),
        .output_bit     (output_bit),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .word_data      (word_data),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .level          (level),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Reference model: words in flight as a plain queue, bits accumulated
    // arithmetically. Evaluated mid-cycle from the inputs about to be
    // sampled at the next rising edge.
    int   exp_q[$];
    int   acc;
    int   nbits;
    bit   ovf;
    bit   started = 1'b0;

    always @(negedge clk) begin
        bit ev;
        ev = 1'b0;
        if (rst) begin
            exp_q.delete();
            acc     = 0;
            nbits   = 0;
            ovf     = 1'b0;
            started = 1'b1;
        end else if (started) begin
            chk("word_valid", int'(word_valid), int'(exp_q.size() != 0));
            chk("level", int'(level), exp_q.size());
            chk("overflow", int'(overflow), int'(ovf));
            if (flush) begin
                exp_q.delete();
                acc   = 0;
                nbits = 0;
            end else begin
                if (exp_q.size() != 0 && word_ready) begin
                    chk("word_data", int'(word_data), exp_q[0]);
                    void'(exp_q.pop_front());
                end
                if (valid_bit) begin
                    acc = acc * 2 + int'(output_bit);
                    nbits++;
                    if (nbits == BW) begin
                        if (exp_q.size() < DP) exp_q.push_back(acc);
                        else ev = 1'b1;
                        acc   = 0;
                        nbits = 0;
                    end
                end
            end
            if (ev) ovf = 1'b1;
            else if (clear_overflow) ovf = 1'b0;
        end
    end

    task automatic step(input bit vb, input bit ob, input bit fl,
                        input bit co, input bit rdy, input bit r);
        valid_bit      = vb;
        output_bit     = ob;
        flush          = fl;
        clear_overflow = co;
        word_ready     = rdy;
        rst            = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy, 0);
    endtask

    task automatic send_word(input logic [BW-1:0] w, input int gap,
                             input bit rdy, input bit rdy_last,
                             input bit co_last);
        for (int i = BW - 1; i >= 0; i--) begin
            if (gap > 0) idle($urandom_range(gap, 0), rdy);
            if (i == 0) step(1, w[i], 0, co_last, rdy_last, 0);
            else        step(1, w[i], 0, 0, rdy, 0);
        end
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("reset word_data", int'(word_data), 0);
        chk("reset level", int'(level), 0);

        // Back-to-back bits, then a single pop.
        send_word(8'hA5, 0, 0, 0, 0);
        chk("A5 latency valid", int'(word_valid), 1);
        chk("A5 data", int'(word_data), 8'hA5);
        idle(1, 1);
        idle(2, 0);

        // Gapped bits.
        send_word(8'h3C, 3, 0, 0, 0);
        idle(2, 0);
        chk("3C data", int'(word_data), 8'h3C);
        idle(2, 1);

        // Overflow on the fifth word, then ordered drain.
        for (int k = 1; k <= 5; k++) send_word(BW'(k), 0, 0, 0, 0);
        chk("full level", int'(level), DP);
        chk("overflow set", int'(overflow), 1);
        step(0, 0, 0, 1, 0, 0);
        idle(6, 1);

        // Push and pop on a full FIFO in the same edge.
        for (int k = 0; k < DP; k++) send_word(BW'(8'h10 + k), 0, 0, 0, 0);
        send_word(8'h77, 0, 0, 1, 0);
        chk("full push+pop level", int'(level), DP);
        chk("full push+pop ovf", int'(overflow), 0);

        // Overflow and clear in the same cycle: set wins.
        send_word(8'h99, 0, 0, 0, 1);
        chk("set wins", int'(overflow), 1);
        idle(6, 1);
        step(0, 0, 0, 1, 0, 0);

        // Flush discards a partial word.
        for (int i = 7; i >= 4; i--) step(1, i < 8 && i >= 4, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        send_word(8'h81, 1, 0, 0, 0);
        chk("flush level", int'(level), 1);
        chk("flush data", int'(word_data), 8'h81);
        idle(2, 1);

        // Reset mid-word with two words buffered.
        send_word(8'hC3, 0, 0, 0, 0);
        send_word(8'h42, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rst data", int'(word_data), 0);
        chk("rst valid", int'(word_valid), 0);
        send_word(8'h5A, 2, 0, 0, 0);
        chk("5A data", int'(word_data), 8'h5A);
        idle(2, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(3, 0) != 0), $urandom_range(1, 0),
                 ($urandom_range(150, 0) == 0),
                 ($urandom_range(20, 0) == 0),
                 ($urandom_range(4, 0) == 0), 0);
        end
        idle(8, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
